tdm_demux_rx: RTL
=================

Name: tdm_demux_rx

Overview:
- Receive-side 1-to-N time-division demultiplexer. It is the counterpart of the team's mux-based selection logic.
- Accepts a word-serial stream in which each frame is CHANNELS consecutive valid words. The first word of a frame is flagged by in_sof.
- Distributes the words into per-channel registers.
- Publishes a complete frame atomically, with a one-cycle valid pulse.
- Sits between a serial link front end and parallel consumer logic.

Parameters:
- WIDTH, 8: bits per channel word.
- CHANNELS, 4: slots per frame. Legal range is 2..16.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data / in_sof qualify this cycle.
- in_sof, input, 1: marks slot 0 of a frame. Ignored when in_valid=0.
- in_data, input, WIDTH: slot word.
- out_data, output, CHANNELS*WIDTH: published frame. Channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid, output, 1: one-cycle pulse; a new frame has been published.
- frame_err, output, 1: one-cycle pulse; a frame was aborted by an early in_sof.
- drop_cnt, output, CNT_W: count of words discarded while IDLE. Saturates at all-ones.
- busy, output, 1: high while in COLLECT.

Behaviour:
- Reset (rst=1 at a clk edge) clears every output to 0: out_data, out_valid, frame_err, drop_cnt, busy. It also clears the state to IDLE, the slot counter to 0, and the shadow buffer. rst wins over any simultaneous input. Reset mid-frame discards the partial frame with no out_valid and no frame_err.
- States: IDLE and COLLECT. busy = (state == COLLECT), registered.
- Internal storage: a slot counter (clog2(CHANNELS) bits) and a shadow buffer of CHANNELS words. out_data changes only on publish.
- IDLE, in_valid=1 and in_sof=1: write in_data to shadow[0], set slot=1, go to COLLECT.
- IDLE, in_valid=1 and in_sof=0: discard the word; drop_cnt += 1, saturating.
- IDLE, in_valid=0: hold.
- COLLECT, in_valid=0: hold. Gaps of any length are allowed inside a frame.
- COLLECT, in_valid=1 and in_sof=0, slot < CHANNELS-1: write shadow[slot], then slot += 1.
- COLLECT, in_valid=1 and in_sof=0, slot == CHANNELS-1 (publish):
  - Write the word.
  - On the same edge, load out_data with the full shadow contents, including this last word, and set out_valid=1 for exactly one cycle.
  - Return to IDLE with slot=0.
- Publish latency: out_data and out_valid are visible the cycle after the last word is sampled.
- COLLECT, in_valid=1 and in_sof=1 (early restart):
  - Pulse frame_err for one cycle. The partial frame is discarded and out_data is unchanged.
  - Treat the word as slot 0 of a new frame: shadow[0]=in_data, slot=1, stay in COLLECT.
- A new frame's in_sof may arrive the cycle immediately after the publishing word. No bubble is required, giving back-to-back throughput of one word per cycle.
- out_data holds the last published frame indefinitely. Older shadow values never leak into out_data: a partial frame is never published.
- out_valid and frame_err are never high in the same cycle.
- drop_cnt does not change in COLLECT.

Test Plan:
- Basic frame (WIDTH=8, CHANNELS=4): reset, then valid words 0x11 (sof), 0x22, 0x33, 0x44 on consecutive cycles -> next cycle out_valid=1 and out_data=0x44332211; the cycle after, out_valid=0 and busy=0.
- Gaps: same frame with in_valid low for 3 cycles between each word -> identical out_data; a single out_valid pulse; busy=1 throughout the frame.
- Early sof: 0xA1 (sof), 0xA2, then 0xB1 (sof), 0xB2, 0xB3, 0xB4 -> frame_err pulses once after 0xB1; out_valid then publishes 0xB4B3B2B1; 0xA* never appears on out_data.
- Idle drops: 3 valid non-sof words while IDLE -> drop_cnt=3; no out_valid. With CNT_W=2, 5 drops -> drop_cnt=3 (saturated).
- Back-to-back: two frames 0x01..0x04 and 0x05..0x08 with no gap -> out_valid on two cycles exactly 4 apart; out_data=0x04030201, then 0x08070605.
- Mid-frame reset: 0x11 (sof), 0x22, rst for 1 cycle, then 0x33, 0x44 without sof -> no out_valid; all outputs 0 after reset; drop_cnt=2.

Source files
------------

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx
// Receive-side 1-to-N time-division demultiplexer. A word-serial stream
// carries frames of CHANNELS consecutive valid words, the first of which is
// flagged by in_sof. Words are collected into a shadow buffer. A complete
// frame is published atomically to out_data with a one-cycle out_valid pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data / in_sof qualify this cycle
//   in_sof     marks slot 0 of a frame (ignored when in_valid=0)
//   in_data    slot word, WIDTH bits
//   out_data   last published frame; channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse: a new frame has been published
//   frame_err  one-cycle pulse: a partial frame was aborted by an early in_sof
//   drop_cnt   saturating count of words discarded while idle
//   busy       high while a frame is being collected
module tdm_demux_rx #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      out_valid,
   output logic                      frame_err,
   output logic [CNT_W-1:0]          drop_cnt,
   output logic                      busy
);

   localparam int                SLOT_W    = $clog2(CHANNELS);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [SLOT_W-1:0]         slot;
   logic [SLOT_W-1:0]         slot_nxt;
   logic [WIDTH-1:0]          shadow [CHANNELS];
   logic                      wr_en;
   logic [SLOT_W-1:0]         wr_idx;
   logic                      publish;
   logic                      abort;
   logic                      drop;
   logic [CHANNELS*WIDTH-1:0] frame_nxt;

   // Next-state and per-word decisions. An in_sof seen while collecting
   // restarts the frame at slot 0 and flags an abort. The word landing on the
   // last slot triggers a publish and the return to idle, so a fresh in_sof
   // can follow on the very next cycle with no bubble.
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      wr_en     = 1'b0;
      wr_idx    = slot;
      publish   = 1'b0;
      abort     = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_sof) begin
                  wr_en     = 1'b1;
                  wr_idx    = '0;
                  slot_nxt  = SLOT_W'(1);
                  state_nxt = COLLECT;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (in_sof) begin
                  abort    = 1'b1;
                  wr_idx   = '0;
                  slot_nxt = SLOT_W'(1);
               end else if (slot == LAST_SLOT) begin
                  publish   = 1'b1;
                  slot_nxt  = '0;
                  state_nxt = IDLE;
               end else begin
                  slot_nxt = slot + SLOT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            slot_nxt  = '0;
         end
      endcase
   end

   // Frame image as it will look once the current word is written. The top
   // channel is taken straight from in_data so that the publishing word
   // reaches out_data on the same edge it is sampled.
   always_comb begin
      frame_nxt = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         frame_nxt[k*WIDTH +: WIDTH] = (k == CHANNELS - 1) ? in_data : shadow[k];
      end
   end

   // State and slot counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         slot  <= '0;
      end else begin
         state <= state_nxt;
         slot  <= slot_nxt;
      end
   end

   // Datapath: shadow buffer, published frame, status pulses and the
   // saturating drop counter. out_data is only ever loaded on publish, so a
   // partially filled shadow buffer can never leak out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) begin
            shadow[k] <= '0;
         end
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (wr_en) begin
            shadow[wr_idx] <= in_data;
         end
         if (publish) begin
            out_data <= frame_nxt;
         end
         out_valid <= publish;
         frame_err <= abort;
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   // busy follows the registered state directly.
   assign busy = (state == COLLECT);

endmodule
